// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans key lines, assigns presses to voices, steals the LRU voice when full.
// Optional sustain-pedal support is compiled in with SIMPLEPIANO_SUSTAIN_EN.
module voice_alloc #(
   parameter int NUM_VOICES = 4,
   parameter int NUM_KEYS   = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [NUM_KEYS-1:0]     keys,
   input  logic [3:0]              octave,
`ifdef SIMPLEPIANO_SUSTAIN_EN
   input  logic                    sustain,
`endif
   output logic [NUM_VOICES-1:0]   voice_active,
   output logic [4*NUM_VOICES-1:0] voice_key,
   output logic [4*NUM_VOICES-1:0] voice_oct,
   output logic [NUM_VOICES-1:0]   voice_trig,
   output logic                    steal
);
   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

   state_t              state;
   logic [3:0]          scan_idx;
   logic [3:0]          next_idx;
   logic [NUM_KEYS-1:0] prev;
   logic                cap;
   logic [IW-1:0]       rank     [NUM_VOICES];
   logic [IW-1:0]       rank_nxt [NUM_VOICES];
   logic [NUM_VOICES-1:0] held;
   logic                sus_lvl;
   logic                sus_q;
   logic                sus_fall;

   logic                free_found;
   logic                match_found;
   logic                reuse;
   logic [IW-1:0]       free_idx;
   logic [IW-1:0]       old_idx;
   logic [IW-1:0]       match_idx;
   logic [IW-1:0]       upd_idx;

`ifdef SIMPLEPIANO_SUSTAIN_EN
   assign sus_lvl = sustain;
`else
   assign sus_lvl = 1'b0;
`endif

   assign sus_fall = sus_q & ~sus_lvl;
   assign next_idx = (scan_idx == 4'(NUM_KEYS-1)) ? 4'd0 : scan_idx + 4'd1;

   // Descending loops leave the lowest matching index in each *_idx.
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      old_idx     = '0;
      match_found = 1'b0;
      match_idx   = '0;
      for (int v = NUM_VOICES-1; v >= 0; v--) begin
         if (!voice_active[v]) begin
            free_found = 1'b1;
            free_idx   = IW'(v);
         end
         if (voice_active[v] && voice_key[4*v +: 4] == scan_idx) begin
            match_found = 1'b1;
            match_idx   = IW'(v);
         end
         if (rank[v] == '0) old_idx = IW'(v);
      end
      reuse   = cap && match_found && held[match_idx];
      upd_idx = reuse ? match_idx : (free_found ? free_idx : old_idx);
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (IW'(v) == upd_idx)             rank_nxt[v] = IW'(NUM_VOICES-1);
         else if (rank[v] > rank[upd_idx]) rank_nxt[v] = rank[v] - IW'(1);
         else                               rank_nxt[v] = rank[v];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         scan_idx     <= '0;
         prev         <= '0;
         cap          <= 1'b0;
         held         <= '0;
         sus_q        <= 1'b0;
         voice_active <= '0;
         voice_key    <= '0;
         voice_oct    <= '0;
         voice_trig   <= '0;
         steal        <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) rank[v] <= IW'(v);
      end else begin
         voice_trig <= '0;
         steal      <= 1'b0;
         sus_q      <= sus_lvl;
         if (!en) begin
            state        <= IDLE;
            scan_idx     <= '0;
            prev         <= '0;
            held         <= '0;
            voice_active <= '0;
         end else begin
            // Pedal release frees held voices and defers any pending UPDATE by one cycle.
            if (sus_fall) begin
               voice_active <= voice_active & ~held;
               held         <= '0;
            end
            case (state)
               IDLE: state <= SCAN;
               SCAN: begin
                  if (keys[scan_idx] != prev[scan_idx]) begin
                     cap   <= keys[scan_idx];
                     state <= UPDATE;
                  end else begin
                     scan_idx <= next_idx;
                  end
               end
               UPDATE: begin
                  if (!sus_fall) begin
                     prev[scan_idx] <= cap;
                     scan_idx       <= next_idx;
                     state          <= SCAN;
                     if (cap) begin
                        voice_trig[upd_idx] <= 1'b1;
                        held[upd_idx]       <= 1'b0;
                        for (int v = 0; v < NUM_VOICES; v++) rank[v] <= rank_nxt[v];
                        if (!reuse) begin
                           voice_active[upd_idx]        <= 1'b1;
                           voice_key[4*upd_idx +: 4]    <= scan_idx;
                           voice_oct[4*upd_idx +: 4]    <= octave;
                           steal                        <= ~free_found;
                        end
                     end else if (match_found) begin
                        if (sus_lvl) held[match_idx]         <= 1'b1;
                        else         voice_active[match_idx] <= 1'b0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed vector table plus randomized key traffic
// checked against an event-level allocation model with an LRU queue.
module tb_voice_alloc;
   localparam int NV     = 4;
   localparam int NK     = 12;
   localparam int SETTLE = 30;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic [NK-1:0]   keys = '0;
   logic [3:0]      octave = '0;
`ifdef SIMPLEPIANO_SUSTAIN_EN
   logic            sustain = 1'b0;
`endif
   logic [NV-1:0]   voice_active;
   logic [4*NV-1:0] voice_key;
   logic [4*NV-1:0] voice_oct;
   logic [NV-1:0]   voice_trig;
   logic            steal;

   voice_alloc #(.NUM_VOICES(NV), .NUM_KEYS(NK)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .keys         (keys),
      .octave       (octave),
`ifdef SIMPLEPIANO_SUSTAIN_EN
      .sustain      (sustain),
`endif
      .voice_active (voice_active),
      .voice_key    (voice_key),
      .voice_oct    (voice_oct),
      .voice_trig   (voice_trig),
      .steal        (steal)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- pulse monitor ----------------
   int trig_tot [NV];
   int steal_tot = 0;
   int trig_base [NV];
   int steal_base = 0;

   initial for (int v = 0; v < NV; v++) trig_tot[v] = 0;

   always @(posedge clk) begin
      #1;
      for (int v = 0; v < NV; v++) trig_tot[v] += int'(voice_trig[v]);
      steal_tot += int'(steal);
   end

   // ---------------- reference model ----------------
   bit         m_act [NV];
   logic [3:0] m_key [NV];
   logic [3:0] m_oct [NV];
   bit         m_lvl [NK];
   int         lru_q [$];
   int         e_trig [NV];
   int         e_steal;

   function automatic void m_reset();
      lru_q = {};
      for (int v = 0; v < NV; v++) begin
         m_act[v] = 1'b0;
         m_key[v] = '0;
         m_oct[v] = '0;
         lru_q.push_back(v);
      end
      for (int k = 0; k < NK; k++) m_lvl[k] = 1'b0;
   endfunction

   function automatic void m_press(input int k, input logic [3:0] oct);
      int a;
      int pos;
      a = -1;
      for (int v = 0; v < NV; v++) if (!m_act[v] && a < 0) a = v;
      if (a < 0) begin
         a = lru_q[0];
         e_steal++;
      end
      pos = 0;
      for (int i = 0; i < lru_q.size(); i++) if (lru_q[i] == a) pos = i;
      lru_q.delete(pos);
      lru_q.push_back(a);
      m_act[a] = 1'b1;
      m_key[a] = 4'(k);
      m_oct[a] = oct;
      e_trig[a]++;
   endfunction

   function automatic void m_release(input int k);
      bit done;
      done = 1'b0;
      for (int v = 0; v < NV; v++)
         if (!done && m_act[v] && m_key[v] == 4'(k)) begin
            m_act[v] = 1'b0;
            done = 1'b1;
         end
   endfunction

   // After re-enable every held key is seen again as a press, scanned from key 0 upward.
   function automatic void m_en_drop(input logic [3:0] oct);
      for (int v = 0; v < NV; v++) m_act[v] = 1'b0;
      for (int k = 0; k < NK; k++) if (m_lvl[k]) m_press(k, oct);
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic begin_window();
      for (int v = 0; v < NV; v++) begin
         trig_base[v] = trig_tot[v];
         e_trig[v] = 0;
      end
      steal_base = steal_tot;
      e_steal = 0;
   endtask

   function automatic logic [31:0] trig_delta();
      logic [31:0] d;
      d = '0;
      for (int v = 0; v < NV; v++) d[4*v +: 4] = 4'(trig_tot[v] - trig_base[v]);
      return d;
   endfunction

   task automatic cmp_model(input string tag);
      logic [NV-1:0]   ea;
      logic [4*NV-1:0] ek, eo, ak, ao;
      logic [31:0]     et;
      ea = '0; ek = '0; eo = '0; ak = '0; ao = '0; et = '0;
      for (int v = 0; v < NV; v++) begin
         ea[v] = m_act[v];
         et[4*v +: 4] = 4'(e_trig[v]);
         if (m_act[v]) begin
            ek[4*v +: 4] = m_key[v];
            eo[4*v +: 4] = m_oct[v];
            ak[4*v +: 4] = voice_key[4*v +: 4];
            ao[4*v +: 4] = voice_oct[4*v +: 4];
         end
      end
      check({tag, " active"}, 32'(voice_active), 32'(ea));
      check({tag, " key"}, 32'(ak), 32'(ek));
      check({tag, " oct"}, 32'(ao), 32'(eo));
      check({tag, " trig"}, trig_delta(), et);
      check({tag, " steal"}, 32'(steal_tot - steal_base), 32'(e_steal));
   endtask

   // ---------------- driver tasks ----------------
   task automatic key_step(input bit press, input int k, input logic [3:0] oct);
      @(negedge clk);
      begin_window();
      octave = oct;
      keys[k] = press;
      m_lvl[k] = press;
      if (press) m_press(k, oct);
      else       m_release(k);
      repeat (SETTLE) @(negedge clk);
   endtask

   task automatic en_pulse();
      @(negedge clk);
      begin_window();
      en = 1'b0;
      @(negedge clk);
      check("en_drop active", 32'(voice_active), 32'd0);
      en = 1'b1;
      m_en_drop(octave);
      repeat (SETTLE) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      keys = '0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit            press;
      int            key;
      int            oct;
      logic [NV-1:0] act;
      logic [NV-1:0] trig;
      bit            stl;
   } vec_t;

   vec_t tbl [16];

   initial begin
      tbl[0]  = '{1'b1, 5,  3, 4'b0001, 4'b0001, 1'b0};
      tbl[1]  = '{1'b0, 5,  3, 4'b0000, 4'b0000, 1'b0};
      tbl[2]  = '{1'b1, 0,  3, 4'b0001, 4'b0001, 1'b0};
      tbl[3]  = '{1'b1, 2,  2, 4'b0011, 4'b0010, 1'b0};
      tbl[4]  = '{1'b1, 4,  5, 4'b0111, 4'b0100, 1'b0};
      tbl[5]  = '{1'b1, 7,  7, 4'b1111, 4'b1000, 1'b0};
      tbl[6]  = '{1'b1, 9,  1, 4'b1111, 4'b0001, 1'b1};
      tbl[7]  = '{1'b1, 11, 4, 4'b1111, 4'b0010, 1'b1};
      tbl[8]  = '{1'b0, 0,  4, 4'b1111, 4'b0000, 1'b0};
      tbl[9]  = '{1'b0, 9,  4, 4'b1110, 4'b0000, 1'b0};
      tbl[10] = '{1'b1, 10, 2, 4'b1111, 4'b0001, 1'b0};
      tbl[11] = '{1'b0, 2,  2, 4'b1111, 4'b0000, 1'b0};
      tbl[12] = '{1'b0, 4,  2, 4'b1011, 4'b0000, 1'b0};
      tbl[13] = '{1'b0, 7,  2, 4'b0011, 4'b0000, 1'b0};
      tbl[14] = '{1'b0, 11, 2, 4'b0001, 4'b0000, 1'b0};
      tbl[15] = '{1'b0, 10, 2, 4'b0000, 4'b0000, 1'b0};

      m_reset();
      begin_window();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst active", 32'(voice_active), 32'd0);
      check("rst key", 32'(voice_key), 32'd0);
      check("rst oct", 32'(voice_oct), 32'd0);
      check("rst trig", 32'(voice_trig), 32'd0);
      check("rst steal", 32'(steal), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      en = 1'b1;

      // Enabled with no keys: nothing ever sounds
      begin_window();
      repeat (40) @(negedge clk);
      cmp_model("idle");

      // Asynchronous reset with two voices sounding, checked between clock edges
      key_step(1'b1, 1, 4'd2);
      key_step(1'b1, 6, 4'd2);
      cmp_model("pre_rst");
      #2 rst_n = 1'b0;
      #1;
      check("async_rst active", 32'(voice_active), 32'd0);
      check("async_rst key", 32'(voice_key), 32'd0);
      check("async_rst oct", 32'(voice_oct), 32'd0);
      keys = '0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Press/release, fill, steal, stolen release
      for (int i = 0; i < 16; i++) begin
         key_step(tbl[i].press, tbl[i].key, 4'(tbl[i].oct));
         check($sformatf("vec%0d active", i), 32'(voice_active), 32'(tbl[i].act));
         for (int v = 0; v < NV; v++) begin
            check($sformatf("vec%0d trig%0d", i, v),
                  32'(trig_tot[v] - trig_base[v]), 32'(tbl[i].trig[v]));
            if (tbl[i].trig[v]) begin
               check($sformatf("vec%0d key%0d", i, v), 32'(voice_key[4*v +: 4]), 32'(tbl[i].key));
               check($sformatf("vec%0d oct%0d", i, v), 32'(voice_oct[4*v +: 4]), 32'(tbl[i].oct));
            end
         end
         check($sformatf("vec%0d steal", i), 32'(steal_tot - steal_base), 32'(tbl[i].stl));
         cmp_model($sformatf("vec%0d", i));
      end

      // Octave change does not retrigger; en drop frees and reallocates with new octave
      key_step(1'b1, 3, 4'd1);
      check("oct_hold initial", 32'(voice_oct[3:0]), 32'd1);
      @(negedge clk);
      begin_window();
      octave = 4'd6;
      repeat (SETTLE) @(negedge clk);
      check("oct_hold unchanged", 32'(voice_oct[3:0]), 32'd1);
      check("oct_hold no trig", trig_delta(), 32'd0);
      en_pulse();
      check("en_realloc active", 32'(voice_active), 32'b0001);
      check("en_realloc oct", 32'(voice_oct[3:0]), 32'd6);
      check("en_realloc key", 32'(voice_key[3:0]), 32'd3);
      cmp_model("en_realloc");
      key_step(1'b0, 3, 4'd6);
      cmp_model("en_release");

`ifdef SIMPLEPIANO_SUSTAIN_EN
      // Sustain: release holds, re-press reuses the same voice, pedal-up frees
      do_reset();
      sustain = 1'b1;
      key_step(1'b1, 4, 4'd2);
      check("sus press active", 32'(voice_active), 32'b0001);
      key_step(1'b0, 4, 4'd2);
      check("sus held active", 32'(voice_active), 32'b0001);
      key_step(1'b1, 4, 4'd2);
      check("sus reuse active", 32'(voice_active), 32'b0001);
      check("sus reuse trig", trig_delta(), 32'h1);
      check("sus reuse steal", 32'(steal_tot - steal_base), 32'd0);
      key_step(1'b0, 4, 4'd2);
      check("sus held2 active", 32'(voice_active), 32'b0001);
      @(negedge clk);
      sustain = 1'b0;
      @(negedge clk);
      check("sus pedal_up active", 32'(voice_active), 32'd0);
      do_reset();
`endif

      // Randomized traffic against the model
      for (int s = 0; s < 60; s++) begin
         int r;
         int k;
         r = $urandom_range(0, 19);
         k = $urandom_range(0, NK-1);
         if (r == 0) en_pulse();
         else        key_step(!m_lvl[k], k, 4'($urandom_range(0, 15)));
         cmp_model($sformatf("rand%0d", s));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Polyphonic voice allocator for the keyboard synth.
- Scans the 12 registered key lines and detects press and release edges per key.
- Assigns each new press to one of NUM_VOICES tone-generator voices. When all voices are busy, it steals the least-recently-allocated voice.
- Sits between the key/octave input registers and the per-voice divider lookup plus tone_gen instances, replacing fixed priority-encoder chaining.

Parameters:
- NUM_VOICES, 4, voice count; legal 2..8.
- NUM_KEYS, 12, key lines scanned; fixed at 12 (key index fits 4 bits).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  allocator enable; low forces idle and frees all voices.
- keys  input  NUM_KEYS  registered key levels, 1 = pressed.
- octave  input  4  registered octave select, sampled at allocation.
- sustain  input  1  sustain pedal; present only with SIMPLEPIANO_SUSTAIN_EN.
- voice_active  output  NUM_VOICES  voice v sounding.
- voice_key  output  4*NUM_VOICES  key index of voice v, bits [4v+3:4v].
- voice_oct  output  4*NUM_VOICES  octave latched for voice v.
- voice_trig  output  NUM_VOICES  one-cycle pulse when voice v is (re)assigned; tone_gen counter restart.
- steal  output  1  one-cycle pulse when an allocation stole a busy voice.

Behaviour:
- Reset is asynchronous and active-low; all state registers clear immediately on rst_n low.
- Reset values:
  - state=IDLE, scan_idx=0, prev[11:0]=0.
  - All voice_active/key/oct=0, voice_trig=0, steal=0.
  - rank of voice v = v.
- FSM states:
  - IDLE: entered on reset or en=0. While en=0: all voices freed, prev cleared, scan_idx=0. Exits to SCAN the cycle after en=1.
  - SCAN: examine keys[scan_idx] against prev[scan_idx].
    - Equal: scan_idx increments, wrapping 11->0; stay in SCAN.
    - Differ: go to UPDATE, holding scan_idx.
  - UPDATE: one cycle. Perform the press/release action for key k=scan_idx, set prev[k]=keys[k] (value captured at the SCAN cycle), increment scan_idx, return to SCAN.
- Press action (prev=0, key=1):
  - If any voice is free, pick the lowest-index free voice.
  - Otherwise pick the active voice with rank 0 (oldest) and pulse steal.
  - Chosen voice: active=1, key=k, oct=octave (sampled in UPDATE), voice_trig pulses in the same cycle the fields update.
- Release action (prev=1, key=0):
  - Free the unique active voice with voice_key==k.
  - No matching voice (the voice was stolen): no-op.
  - Freeing does not change rank.
- Rank (LRU):
  - Ranks are a permutation of 0..NUM_VOICES-1.
  - On allocating voice a with old rank r: every voice with rank>r decrements, and voice a gets rank NUM_VOICES-1.
- Latency: a held level is reflected in voice outputs within 2*NUM_KEYS cycles worst case, 2 cycles best case (SCAN already at that key).
- A press+release shorter than one scan pass may be missed. This is accepted, and acts as a glitch filter.
- Octave changes never retrigger a voice already sounding; only new allocations sample octave.
- A stolen key stays prev=1. It is not reallocated until it is released and pressed again.
- en dropping mid-UPDATE: IDLE wins, and no allocation completes.
- voice_trig and steal are registered outputs, zero outside UPDATE.

Optional Feature:
- Macro SIMPLEPIANO_SUSTAIN_EN.
- Defined:
  - sustain port exists, plus a per-voice held flag.
  - A release while sustain=1 sets held instead of freeing; the voice stays active.
  - On the sustain 1->0 edge, all held voices free in one cycle. This has priority over any UPDATE in the same cycle, which then completes the next cycle.
  - A press of a key already held by a voice reuses that voice: it clears held and pulses voice_trig. No new allocation is made and rank is refreshed to newest.
- Undefined: no sustain port; releases free immediately.

Test Plan:
- Reset/idle: assert rst_n=0 mid-scan with 2 voices active -> all outputs 0 immediately without a clock edge. Release reset, en=1, no keys -> outputs stay 0 indefinitely.
- Basic press/release: octave=3, press key 5 -> within 24 cycles voice 0 active, key=5, oct=3, one voice_trig[0] pulse. Release key 5 -> voice_active[0]=0 within 24 cycles.
- Fill and steal (NUM_VOICES=4): press keys 0,2,4,7 sequentially (each settled), then key 9 -> voice 0 reassigned to key 9, steal pulses once, voice_trig[0] pulses. Later press 11 -> steals voice 1 (key 2).
- Stolen release: continue from the previous scenario and release key 0 -> no voice changes. Release key 9 -> voice 0 freed. Press 10 -> lands on voice 0 with no steal.
- Octave and en: hold key 3 at octave 1, change octave to 6 -> voice_oct unchanged. Drop en for 1 cycle -> all voices freed. With en back high, key 3 reallocates with oct=6.
- Sustain (SIMPLEPIANO_SUSTAIN_EN): sustain=1, press and release key 4 -> voice stays active. Press 4 again -> same voice retriggers. Release, then drop sustain -> voice freed the cycle after the sustain edge.
